// File: rtl/even_counter_sequencer.sv
// even_counter_sequencer
// Controller for a 4-bit even up/down counter that steps by 2 per clock.
// It accepts "move to even target" commands on a valid/ready handshake and
// picks a direction, either the explicit one or the shortest path. It then
// drives cnt_en for exactly the required number of steps, checks where the
// counter landed, and reports done together with err/aborted.
// Optional feature macro: SEQ_STEP_COUNT_EN adds the step_total and
// last_steps outputs.
module even_counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_auto,
    input  logic             cmd_dir,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_y,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted
`ifdef SEQ_STEP_COUNT_EN
    ,
    output logic [15:0]      step_total,
    output logic [WIDTH-1:0] last_steps
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        CHECK,
        RESP
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] target_q;
    logic             auto_q;
    logic             dir_q;
    logic [WIDTH-1:0] remaining_q;
    logic             cnt_y_q;
    logic             cnt_en_q;
    logic             done_q;
    logic             err_q;
    logic             aborted_q;

    logic [WIDTH-1:0] upDiff;
    logic [WIDTH-1:0] downDiff;
    logic [WIDTH-1:0] upSteps;
    logic [WIDTH-1:0] downSteps;
    logic             dirSel;
    logic [WIDTH-1:0] steps;

    // Modulo distance to the target in both directions, halved because each
    // counter step moves the value by two; auto mode prefers up on a tie.
    always_comb begin
        upDiff    = target_q - cnt_q;
        downDiff  = cnt_q - target_q;
        upSteps   = upDiff >> 1;
        downSteps = downDiff >> 1;
        dirSel    = auto_q ? (downSteps < upSteps) : dir_q;
        steps     = dirSel ? downSteps : upSteps;
    end

    // Main sequencer FSM. All handshake and counter-control outputs are
    // registered here, and reset drops cnt_en immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            auto_q      <= 1'b0;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            cnt_y_q     <= 1'b0;
            cnt_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    aborted_q <= 1'b0;
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        auto_q   <= cmd_auto;
                        dir_q    <= cmd_dir;
                        if (cmd_target[0]) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q[0]) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_y_q <= dirSel;
                        if (steps == '0) begin
                            state_q <= CHECK;
                        end else begin
                            remaining_q <= steps;
                            cnt_en_q    <= 1'b1;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        cnt_en_q  <= 1'b0;
                        state_q   <= RESP;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (remaining_q == ONE) begin
                        cnt_en_q <= 1'b0;
                        state_q  <= CHECK;
                    end else begin
                        remaining_q <= remaining_q - ONE;
                    end
                end
                CHECK: begin
                    state_q <= RESP;
                    done_q  <= 1'b1;
                    err_q   <= (cnt_q != target_q);
                end
                RESP: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_en_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cnt_y     = cnt_y_q;
    assign cnt_en    = cnt_en_q;
    assign done      = done_q;
    assign err       = err_q;
    assign aborted   = aborted_q;

`ifdef SEQ_STEP_COUNT_EN
    logic [15:0]      step_total_q;
    logic [WIDTH-1:0] last_steps_q;

    // Saturating tally of enabled counter cycles, plus the step count
    // computed for the latest command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_total_q <= '0;
            last_steps_q <= '0;
        end else begin
            if (cnt_en_q && (step_total_q != 16'hFFFF)) begin
                step_total_q <= step_total_q + 16'd1;
            end
            if (state_q == SETUP) begin
                last_steps_q <= steps;
            end
        end
    end

    assign step_total = step_total_q;
    assign last_steps = last_steps_q;
`endif

endmodule

// File: tb/tb_even_counter_sequencer.sv
// Self-checking bench for even_counter_sequencer.
// A behavioural model of the even counter sits in the bench and feeds cnt_q
// back to the sequencer. A table of directed commands covers direction
// choice, wrap-around, ties, zero steps, odd inputs and a stuck counter.
// Hand-written sequences cover abort and a reset during a move.
module tb_even_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_target;
    logic       cmd_auto;
    logic       cmd_dir;
    logic       abort;
    logic [3:0] cntModel;
    logic       cnt_y;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic       err;
    logic       aborted;
`ifdef SEQ_STEP_COUNT_EN
    logic [15:0] step_total;
    logic [3:0]  last_steps;
`endif

    logic       loadReq;
    logic [3:0] loadVal;
    logic       freeze;
    int         totalEn;

    int checks;
    int errors;

    even_counter_sequencer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_auto   (cmd_auto),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .cnt_q      (cntModel),
        .cnt_y      (cnt_y),
        .cnt_en     (cnt_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .aborted    (aborted)
`ifdef SEQ_STEP_COUNT_EN
        ,
        .step_total (step_total),
        .last_steps (last_steps)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Even counter model: steps by two when enabled. It can be preloaded,
    // or frozen to imitate a broken counter.
    always @(posedge clk) begin
        if (loadReq)
            cntModel <= loadVal;
        else if (cnt_en && !freeze)
            cntModel <= cnt_y ? cntModel - 4'd2 : cntModel + 4'd2;
    end

    // Independent tally of enabled cycles since the last reset.
    always @(posedge clk or posedge reset) begin
        if (reset)
            totalEn <= 0;
        else if (cnt_en)
            totalEn <= totalEn + 1;
    end

    typedef struct {
        logic [3:0] start;
        logic [3:0] target;
        bit         autoM;
        bit         dir;
        bit         frz;
        int         expLat;
        int         expEn;
        logic       expY;
        logic       expErr;
        logic [3:0] expEnd;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setCounter(input logic [3:0] v);
        @(negedge clk);
        loadReq = 1'b1;
        loadVal = v;
        @(negedge clk);
        loadReq = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] target, input bit autoM, input bit dir);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = target;
        cmd_auto   = autoM;
        cmd_dir    = dir;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Issues one command and watches it to completion, reporting the
    // latency from accept edge to done and what was observed on the way.
    task automatic runCommand(input string tag, input logic [3:0] target, input bit autoM,
                              input bit dir, output int lat, output int enCnt,
                              output logic yOut, output logic errOut, output logic abOut);
        lat    = 0;
        enCnt  = 0;
        yOut   = 1'b0;
        errOut = 1'b0;
        abOut  = 1'b0;
        applyStimulus(target, autoM, dir);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput({tag, "_busy"}, busy, 1);
                checkOutput({tag, "_ready_low"}, cmd_ready, 0);
            end
            if (cnt_en) enCnt++;
            if (done) begin
                lat    = k;
                yOut   = cnt_y;
                errOut = err;
                abOut  = aborted;
                break;
            end
        end
        if (lat == 0) begin
            checkOutput({tag, "_done_timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            checkOutput({tag, "_done_pulse"}, done, 0);
            checkOutput({tag, "_ready_after"}, cmd_ready, 1);
        end
    endtask

    // Main test sequence.
    initial begin
        int         lat;
        int         enCnt;
        logic       yOut;
        logic       errOut;
        logic       abOut;
        string      tag;
        logic [3:0] upS;
        logic [3:0] dnS;
        logic [3:0] expLast;

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 4'd0;
        cmd_auto   = 1'b0;
        cmd_dir    = 1'b0;
        abort      = 1'b0;
        loadReq    = 1'b0;
        loadVal    = 4'd0;
        freeze     = 1'b0;

        //           start target auto dir frz lat en  y     err   end
        vecs[0] = '{4'd0,  4'd6,  1, 0, 0,  6, 3, 1'b0, 1'b0, 4'd6};
        vecs[1] = '{4'd14, 4'd2,  1, 0, 0,  5, 2, 1'b0, 1'b0, 4'd2};
        vecs[2] = '{4'd8,  4'd0,  1, 0, 0,  7, 4, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{4'd8,  4'd0,  0, 1, 0,  7, 4, 1'b1, 1'b0, 4'd0};
        vecs[4] = '{4'd4,  4'd5,  0, 0, 0,  1, 0, 1'b1, 1'b1, 4'd4};
        vecs[5] = '{4'd4,  4'd4,  1, 0, 0,  3, 0, 1'b0, 1'b0, 4'd4};
        vecs[6] = '{4'd2,  4'd12, 1, 0, 0,  6, 3, 1'b1, 1'b0, 4'd12};
        vecs[7] = '{4'd3,  4'd4,  1, 0, 0,  2, 0, 1'b1, 1'b1, 4'd3};
        vecs[8] = '{4'd6,  4'd4,  0, 0, 0, 10, 7, 1'b0, 1'b0, 4'd4};
        vecs[9] = '{4'd0,  4'd4,  1, 0, 1,  5, 2, 1'b0, 1'b1, 4'd0};

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", cmd_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_en", cnt_en, 0);
        checkOutput("reset_y", cnt_y, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_aborted", aborted, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("row%0d", i);
            setCounter(vecs[i].start);
            freeze = vecs[i].frz;
            runCommand(tag, vecs[i].target, vecs[i].autoM, vecs[i].dir, lat, enCnt, yOut, errOut, abOut);
            freeze = 1'b0;
            checkOutput({tag, "_latency"}, lat, vecs[i].expLat);
            checkOutput({tag, "_en_cycles"}, enCnt, vecs[i].expEn);
            checkOutput({tag, "_y"}, yOut, vecs[i].expY);
            checkOutput({tag, "_err"}, errOut, vecs[i].expErr);
            checkOutput({tag, "_aborted"}, abOut, 0);
            checkOutput({tag, "_cnt_end"}, cntModel, vecs[i].expEnd);
`ifdef SEQ_STEP_COUNT_EN
            if (!vecs[i].target[0] && !vecs[i].start[0]) begin
                upS     = (vecs[i].target - vecs[i].start) >> 1;
                dnS     = (vecs[i].start - vecs[i].target) >> 1;
                expLast = (vecs[i].autoM ? (dnS < upS) : vecs[i].dir) ? dnS : upS;
                checkOutput({tag, "_last_steps"}, last_steps, expLast);
            end
`else
            upS     = 4'd0;
            dnS     = 4'd0;
            expLast = 4'd0;
`endif
        end

        // Abort after two RUN cycles of a six-step manual up move.
        setCounter(4'd0);
        applyStimulus(4'd12, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_en_run1", cnt_en, 1);
        @(negedge clk);
        checkOutput("abort_en_run2", cnt_en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_done", done, 1);
        checkOutput("abort_aborted", aborted, 1);
        checkOutput("abort_err", err, 0);
        checkOutput("abort_en_off", cnt_en, 0);
        checkOutput("abort_cnt", cntModel, 4);
        @(negedge clk);
        checkOutput("abort_done_clear", done, 0);
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_cnt_held", cntModel, 4);

        // Reset in the middle of a down move; abort during SETUP is ignored.
        setCounter(4'd8);
        applyStimulus(4'd2, 1'b0, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("rst_en_run", cnt_en, 1);
        checkOutput("rst_y_down", cnt_y, 1);
        @(negedge clk);
        checkOutput("rst_cnt_before", cntModel, 6);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_en_drop", cnt_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_y", cnt_y, 0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_cnt_held", cntModel, 6);
        runCommand("after_rst", 4'd2, 1'b1, 1'b0, lat, enCnt, yOut, errOut, abOut);
        checkOutput("after_rst_latency", lat, 5);
        checkOutput("after_rst_en_cycles", enCnt, 2);
        checkOutput("after_rst_y", yOut, 1);
        checkOutput("after_rst_err", errOut, 0);
        checkOutput("after_rst_cnt_end", cntModel, 2);

`ifdef SEQ_STEP_COUNT_EN
        checkOutput("step_total", step_total, totalEn);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
